// File: rtl/fp2_sqr4.sv
// fp2_sqr4 / fp_mul
//
// fp_mul: pipelined modular multiplier over p = 5*2^248 - 1. Operands are
// sampled on a clock edge and the reduced product leaves the last of
// LATENCY registers. The datapath has no reset; consumers must qualify
// its output with their own valid tags.
//   clk  : clock
//   a_i  : operand, < p
//   b_i  : operand, < p
//   p_o  : a_i * b_i mod p, LATENCY cycles after the operands are presented
//
// fp2_sqr4: squares four Fp2 coordinates (x, y, z, t) with one shared fp_mul.
// Each coordinate uses (a + bi)^2 = (a+b)(a-b) + 2ab*i, so eight products
// are issued per set.
//   clk, rst             : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, set accepted when both are high
//   x_re .. t_im         : input coordinates, each < p
//   out_valid / out_ready: output handshake, results retire when both are high
//   out_x_re .. out_t_im : squared coordinates, each < p
//   dbg_state_o          : current FSM state
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never depends on ready, and data is stable while
// valid is high and ready is low.

module fp_mul #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic [254:0] a_i,
  input  logic [254:0] b_i,
  output logic [254:0] p_o
);
  localparam logic [509:0] P_W = 510'((256'd5 << 248) - 256'd1);

  logic [509:0] prod_full;
  logic [254:0] prod_mod;
  logic [254:0] pipe_q [LATENCY];

  assign prod_full = {255'd0, a_i} * {255'd0, b_i};
  assign prod_mod  = 255'(prod_full % P_W);

  always_ff @(posedge clk) begin
    pipe_q[0] <= prod_mod;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign p_o = pipe_q[LATENCY-1];
endmodule

module fp2_sqr4 #(
  parameter int LATENCY_FP_MUL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [254:0] x_re,
  input  logic [254:0] x_im,
  input  logic [254:0] y_re,
  input  logic [254:0] y_im,
  input  logic [254:0] z_re,
  input  logic [254:0] z_im,
  input  logic [254:0] t_re,
  input  logic [254:0] t_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [254:0] out_x_re,
  output logic [254:0] out_x_im,
  output logic [254:0] out_y_re,
  output logic [254:0] out_y_im,
  output logic [254:0] out_z_re,
  output logic [254:0] out_z_im,
  output logic [254:0] out_t_re,
  output logic [254:0] out_t_im,
  output logic [2:0]   dbg_state_o
);
  localparam int LATENCY_FP2_SQR4 = LATENCY_FP_MUL + 10;
  localparam logic [254:0] P = 255'((256'd5 << 248) - 256'd1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [254:0] a_q [4];
  logic [254:0] b_q [4];
  logic [254:0] s_q [4];
  logic [254:0] d_q [4];
  logic [254:0] out_re_q [4];
  logic [254:0] out_im_q [4];
  logic [254:0] in_re [4];
  logic [254:0] in_im [4];
  logic [2:0]   k_q;
  logic         tag_v_q [LATENCY_FP_MUL];
  logic [2:0]   tag_k_q [LATENCY_FP_MUL];
  logic         last_q;
  logic [254:0] op_a, op_b, mul_p;
  logic         ret_v;
  logic [2:0]   ret_k;
  logic         issue;

  function automatic logic [254:0] mod_add(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return 255'(s);
  endfunction

  // When a < b the 255-bit wrap of a - b plus p lands exactly on a - b + p.
  function automatic logic [254:0] mod_sub(input logic [254:0] a, input logic [254:0] b);
    return (a >= b) ? (a - b) : (a - b + P);
  endfunction

  assign in_re[0] = x_re; assign in_im[0] = x_im;
  assign in_re[1] = y_re; assign in_im[1] = y_im;
  assign in_re[2] = z_re; assign in_im[2] = z_im;
  assign in_re[3] = t_re; assign in_im[3] = t_im;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign dbg_state_o = state_q;
  assign issue       = (state_q == S_ISSUE);

  // Even k squares via s*d, odd k forms the cross product a*b.
  assign op_a = k_q[0] ? a_q[k_q[2:1]] : s_q[k_q[2:1]];
  assign op_b = k_q[0] ? b_q[k_q[2:1]] : d_q[k_q[2:1]];

  fp_mul #(.LATENCY(LATENCY_FP_MUL)) u_mul (
    .clk (clk),
    .a_i (op_a),
    .b_i (op_b),
    .p_o (mul_p)
  );

  assign ret_v = tag_v_q[LATENCY_FP_MUL-1];
  assign ret_k = tag_k_q[LATENCY_FP_MUL-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_PREP;
      S_PREP:  state_d = S_ISSUE;
      S_ISSUE: if (k_q == 3'd7) state_d = S_DRAIN;
      S_DRAIN: if (last_q) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Input capture, s/d precompute and issue counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 4; j++) begin
        a_q[j] <= '0; b_q[j] <= '0; s_q[j] <= '0; d_q[j] <= '0;
      end
      k_q <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        for (int j = 0; j < 4; j++) begin
          a_q[j] <= in_re[j];
          b_q[j] <= in_im[j];
        end
      end
      if (state_q == S_PREP) begin
        for (int j = 0; j < 4; j++) begin
          s_q[j] <= mod_add(a_q[j], b_q[j]);
          d_q[j] <= mod_sub(a_q[j], b_q[j]);
        end
      end
      k_q <= issue ? k_q + 3'd1 : 3'd0;
    end
  end

  // Tags travel beside fp_mul; clearing them on reset drops in-flight products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY_FP_MUL; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_k_q[i] <= '0;
      end
      last_q <= 1'b0;
    end else begin
      tag_v_q[0] <= issue;
      tag_k_q[0] <= k_q;
      for (int i = 1; i < LATENCY_FP_MUL; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_k_q[i] <= tag_k_q[i-1];
      end
      last_q <= ret_v && (ret_k == 3'd7);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 4; j++) begin
        out_re_q[j] <= '0;
        out_im_q[j] <= '0;
      end
    end else if (ret_v) begin
      if (!ret_k[0]) out_re_q[ret_k[2:1]] <= mul_p;
      else           out_im_q[ret_k[2:1]] <= mod_add(mul_p, mul_p);
    end
  end

  assign out_x_re = out_re_q[0]; assign out_x_im = out_im_q[0];
  assign out_y_re = out_re_q[1]; assign out_y_im = out_im_q[1];
  assign out_z_re = out_re_q[2]; assign out_z_im = out_im_q[2];
  assign out_t_re = out_re_q[3]; assign out_t_im = out_im_q[3];
endmodule

// File: tb/tb_fp2_sqr4.sv
// Self-checking bench for fp2_sqr4: directed Fp2 squares, boundary values,
// back-pressure, mid-operation reset and random hadamard-fed sets, checked
// against a plain-arithmetic Fp2 square model.
module tb_fp2_sqr4;
  localparam int LAT_MUL = 4;
  localparam int LAT     = LAT_MUL + 10;
  localparam logic [254:0] P = 255'((256'd5 << 248) - 256'd1);
  localparam int W = 8 * 255;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [254:0] x_re, x_im, y_re, y_im, z_re, z_im, t_re, t_im;
  logic [254:0] out_x_re, out_x_im, out_y_re, out_y_im;
  logic [254:0] out_z_re, out_z_im, out_t_re, out_t_im;
  logic [2:0]   dbg_state;
  logic [W-1:0] dut_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  string names[8] = '{"x_re", "x_im", "y_re", "y_im", "z_re", "z_im", "t_re", "t_im"};

  fp2_sqr4 #(.LATENCY_FP_MUL(LAT_MUL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .z_re(z_re), .z_im(z_im), .t_re(t_re), .t_im(t_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
    .out_z_re(out_z_re), .out_z_im(out_z_im), .out_t_re(out_t_re), .out_t_im(out_t_im),
    .dbg_state_o(dbg_state)
  );

  assign dut_out = {out_x_re, out_x_im, out_y_re, out_y_im, out_z_re, out_z_im, out_t_re, out_t_im};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [254:0] got, input logic [254:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [254:0] coord(input logic [W-1:0] v, input int i);
    return v[(7-i)*255 +: 255];
  endfunction

  function automatic logic [254:0] fadd(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] r;
    r = ({257'd0, a} + {257'd0, b}) % {257'd0, P};
    return 255'(r);
  endfunction

  function automatic logic [254:0] fsub(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] r;
    r = ({257'd0, a} + {257'd0, P} - {257'd0, b}) % {257'd0, P};
    return 255'(r);
  endfunction

  function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] r;
    r = ({257'd0, a} * {257'd0, b}) % {257'd0, P};
    return 255'(r);
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [254:0] a, b;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      a = coord(v, 2*j);
      b = coord(v, 2*j+1);
      r[(7-2*j)*255 +: 255]   = fsub(fmul(a, a), fmul(b, b));
      r[(7-2*j-1)*255 +: 255] = fadd(fmul(a, b), fmul(a, b));
    end
    return r;
  endfunction

  function automatic logic [254:0] rnd_fp();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return 255'(r % {1'b0, P});
  endfunction

  // Hadamard of four Fp2 points, applied to re and im parts independently.
  function automatic logic [W-1:0] hadamard(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [254:0] x, y, z, t;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      x = coord(v, c); y = coord(v, 2 + c); z = coord(v, 4 + c); t = coord(v, 6 + c);
      r[(7-c)*255 +: 255]   = fadd(fadd(x, y), fadd(z, t));
      r[(5-c)*255 +: 255]   = fsub(fadd(x, z), fadd(y, t));
      r[(3-c)*255 +: 255]   = fsub(fadd(x, y), fadd(z, t));
      r[(1-c)*255 +: 255]   = fsub(fadd(x, t), fadd(y, z));
    end
    return r;
  endfunction

  // driver tasks
  task automatic set_inputs(input logic [W-1:0] v);
    x_re = coord(v, 0); x_im = coord(v, 1); y_re = coord(v, 2); y_im = coord(v, 3);
    z_re = coord(v, 4); z_im = coord(v, 5); t_re = coord(v, 6); t_im = coord(v, 7);
  endtask

  // Returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (n >= 100) check("in_ready_timeout", 255'(in_ready), 255'd1);
    set_inputs(v);
    in_valid = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_after_accept", 255'(in_ready), 255'd0);
  endtask

  task automatic receive(input bit chk_lat, input bit do_hs, output logic [W-1:0] e);
    int  n;
    bit  rdy_seen;
    n = 0;
    rdy_seen = 0;
    while (!out_valid && n < 300) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); @(negedge clk); n++;
    end
    check("out_valid_seen", 255'(out_valid), 255'd1);
    if (chk_lat) begin
      check("latency", 255'(n), 255'(LAT));
      check("in_ready_low_while_busy", 255'(rdy_seen), 255'd0);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < 8; i++) check(names[i], coord(dut_out, i), coord(e, i));
    if (do_hs) begin
      @(posedge clk); @(negedge clk);
      check("out_valid_after_hs", 255'(out_valid), 255'd0);
      check("in_ready_after_hs", 255'(in_ready), 255'd1);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [254:0] c0, c1, c2, c3, c4, c5, c6, c7);
    return {c0, c1, c2, c3, c4, c5, c6, c7};
  endfunction

  initial begin
    logic [W-1:0] v, e, held;
    logic [254:0] r;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_inputs('0);
    #12;
    check("rst_in_ready", 255'(in_ready), 255'd1);
    check("rst_out_valid", 255'(out_valid), 255'd0);
    for (int i = 0; i < 8; i++) check({"rst_", names[i]}, coord(dut_out, i), 255'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // x = 3 -> 9, with latency check
    send(pack(255'd3, 0, 0, 0, 0, 0, 0, 0));
    receive(1, 1, e);
    check("x3_sq_const", out_x_re, 255'd9);

    // x = 1+1i, y = 2+3i
    send(pack(255'd1, 255'd1, 255'd2, 255'd3, 0, 0, 0, 0));
    receive(1, 1, e);
    check("y_re_const", out_y_re, P - 255'd5);
    check("y_im_const", out_y_im, 255'd12);

    // z = (p-1)+0i, t = 0+(p-1)i: wrap paths
    send(pack(0, 0, 0, 0, P - 255'd1, 0, 0, P - 255'd1));
    receive(1, 1, e);
    check("z_re_const", out_z_re, 255'd1);
    check("t_re_const", out_t_re, P - 255'd1);

    // a = b, a+b = p-1, a+b = p, larger values
    r = rnd_fp();
    send(pack(r, r, P - 255'd3, 255'd2, P - 255'd2, 255'd2, P - 255'd1, P - 255'd1));
    receive(1, 1, e);

    // back-pressure: hold out_ready low, toggle in_valid with fresh data
    out_ready = 1'b0;
    send(pack(255'd7, 255'd5, 255'd11, 255'd13, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()));
    receive(1, 0, held);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 8; i++) v[(7-i)*255 +: 255] = rnd_fp();
      set_inputs(v);
      in_valid = c[0];
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", 255'(out_valid), 255'd1);
      check("bp_in_ready", 255'(in_ready), 255'd0);
      check("bp_hold", coord(dut_out, c % 8), coord(held, c % 8));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_release_in_ready", 255'(in_ready), 255'd1);
    check("bp_release_out_valid", 255'(out_valid), 255'd0);

    // reset during ISSUE
    send(pack(rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp()));
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 255'(out_valid), 255'd0);
    check("midrst_in_ready", 255'(in_ready), 255'd1);
    for (int i = 0; i < 8; i++) check({"midrst_", names[i]}, coord(dut_out, i), 255'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    send(pack(255'd3, 0, 0, 0, 0, 0, 0, 0));
    receive(1, 1, e);

    // random hadamard-fed sets, back-to-back
    for (int s = 0; s < 200; s++) begin
      for (int i = 0; i < 8; i++) v[(7-i)*255 +: 255] = rnd_fp();
      send(hadamard(v));
      receive(0, 1, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
